// File: rtl/raster_pkg.sv
// Shared types for the triangle traversal engine: coordinate/edge widths,
// edge-equation record, FSM encoding and small arithmetic helpers.
package raster_pkg;

    localparam int COORD_W = 11;
    localparam int COEFF_W = 12;
    localparam int EDGE_W  = 22;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic signed [EDGE_W-1:0]  edge_t;

    // E(x,y) = a*x + b*y + c
    typedef struct packed {
        coeff_t a;
        coeff_t b;
        edge_t  c;
    } edge_eq_t;

    typedef enum logic [2:0] {IDLE, SETUP, INIT, WALK, DRAIN, DONE} state_t;

    function automatic coord_t min3(coord_t p, coord_t q, coord_t r);
        coord_t m;
        m = (p < q) ? p : q;
        return (m < r) ? m : r;
    endfunction

    function automatic coord_t max3(coord_t p, coord_t q, coord_t r);
        coord_t m;
        m = (p > q) ? p : q;
        return (m > r) ? m : r;
    endfunction

    // Evaluate an edge equation; everything wraps in EDGE_W bits.
    function automatic edge_t edge_eval(edge_eq_t eq, edge_t x, edge_t y);
        return edge_t'(eq.a) * x + edge_t'(eq.b) * y + eq.c;
    endfunction

endpackage

// File: rtl/raster_traversal_edge_setup.sv
// Combinational edge-equation builder for the directed edge i->j.
module edge_setup
    import raster_pkg::*;
(
    input  coord_t   xi,
    input  coord_t   yi,
    input  coord_t   xj,
    input  coord_t   yj,
    output edge_eq_t eq
);

    // A and B fit 12 bits exactly; C wraps in 22 bits like all later accumulation.
    always_comb begin
        eq.a = coeff_t'(yi) - coeff_t'(yj);
        eq.b = coeff_t'(xj) - coeff_t'(xi);
        eq.c = edge_t'(xi) * edge_t'(yj) - edge_t'(xj) * edge_t'(yi);
    end

endmodule

// File: rtl/raster_traversal.sv
// Triangle traversal: edge setup, clamped bounding box, row-major incremental
// walk and a single fragment output register with valid/ready backpressure.
module raster_traversal
    import raster_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic signed [10:0] v0_x,
    input  logic signed [10:0] v0_y,
    input  logic signed [10:0] v1_x,
    input  logic signed [10:0] v1_y,
    input  logic signed [10:0] v2_x,
    input  logic signed [10:0] v2_y,
    output logic               frag_valid,
    input  logic               frag_ready,
    output logic [10:0]        frag_x,
    output logic [10:0]        frag_y,
    output logic signed [21:0] frag_w0,
    output logic signed [21:0] frag_w1,
    output logic signed [21:0] frag_w2,
    output logic               tri_done
);

    localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1);

    state_t            state, state_nxt;
    coord_t            vx [3];
    coord_t            vy [3];
    edge_eq_t          eq_raw [3];
    edge_eq_t          eq_or [3];
    edge_eq_t          eq [3];
    edge_t             e_init [3];
    edge_t             erow [3];
    edge_t             ecur [3];
    edge_t             area;
    logic signed [11:0] x_lo, x_hi, y_lo, y_hi;
    logic [10:0]       minx, maxx, miny, maxy, x, y;
    logic              degen, empty, step, last, covered;

    // Edge k runs from vertex k+1 to vertex k+2, so w0 is v1->v2, w1 v2->v0, w2 v0->v1.
    for (genvar k = 0; k < 3; k++) begin : g_edge
        edge_setup u_edge (
            .xi (vx[(k+1)%3]),
            .yi (vy[(k+1)%3]),
            .xj (vx[(k+2)%3]),
            .yj (vy[(k+2)%3]),
            .eq (eq_raw[k])
        );
    end

    // Setup: orientation, degenerate detection and screen-clamped bounding box.
    always_comb begin
        area  = edge_eval(eq_raw[2], edge_t'(vx[2]), edge_t'(vy[2]));
        degen = (area == '0);
        for (int i = 0; i < 3; i++) begin
            eq_or[i].a = area[21] ? -eq_raw[i].a : eq_raw[i].a;
            eq_or[i].b = area[21] ? -eq_raw[i].b : eq_raw[i].b;
            eq_or[i].c = area[21] ? -eq_raw[i].c : eq_raw[i].c;
        end
        x_lo = 12'(min3(vx[0], vx[1], vx[2]));
        x_hi = 12'(max3(vx[0], vx[1], vx[2]));
        y_lo = 12'(min3(vy[0], vy[1], vy[2]));
        y_hi = 12'(max3(vy[0], vy[1], vy[2]));
        if (x_lo < 12'sd0) x_lo = 12'sd0;
        if (y_lo < 12'sd0) y_lo = 12'sd0;
        if (x_hi > X_MAX)  x_hi = X_MAX;
        if (y_hi > Y_MAX)  y_hi = Y_MAX;
        empty = (x_lo > x_hi) || (y_lo > y_hi);
    end

    // Walk-side helpers: starting edge values, coverage and advance qualifier.
    always_comb begin
        for (int i = 0; i < 3; i++)
            e_init[i] = edge_eval(eq[i], edge_t'(minx), edge_t'(miny));
        covered = !ecur[0][21] && !ecur[1][21] && !ecur[2][21];
        step    = (state == WALK) && (!frag_valid || frag_ready);
        last    = (x == maxx) && (y == maxy);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        tri_ready = 1'b0;
        tri_done  = 1'b0;
        case (state)
            IDLE: begin
                tri_ready = 1'b1;
                if (tri_valid) state_nxt = SETUP;
            end
            SETUP:   state_nxt = (degen || empty) ? DONE : INIT;
            INIT:    state_nxt = WALK;
            WALK:    if (step && last) state_nxt = DRAIN;
            DRAIN:   if (!frag_valid || frag_ready) state_nxt = DONE;
            DONE: begin
                tri_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture vertices, latch setup, seed and step the edge accumulators.
    always_ff @(posedge clk) begin
        if (state == IDLE && tri_valid) begin
            vx[0] <= v0_x; vy[0] <= v0_y;
            vx[1] <= v1_x; vy[1] <= v1_y;
            vx[2] <= v2_x; vy[2] <= v2_y;
        end
        if (state == SETUP) begin
            for (int i = 0; i < 3; i++) eq[i] <= eq_or[i];
            minx <= x_lo[10:0];
            maxx <= x_hi[10:0];
            miny <= y_lo[10:0];
            maxy <= y_hi[10:0];
        end
        if (state == INIT) begin
            for (int i = 0; i < 3; i++) begin
                erow[i] <= e_init[i];
                ecur[i] <= e_init[i];
            end
            x <= minx;
            y <= miny;
        end
        if (step) begin
            if (x < maxx) begin
                x <= x + 11'd1;
                for (int i = 0; i < 3; i++) ecur[i] <= ecur[i] + edge_t'(eq[i].a);
            end else begin
                x <= minx;
                y <= y + 11'd1;
                for (int i = 0; i < 3; i++) begin
                    erow[i] <= erow[i] + edge_t'(eq[i].b);
                    ecur[i] <= erow[i] + edge_t'(eq[i].b);
                end
            end
        end
    end

    // Fragment register: load on a covered step, clear on acceptance, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            frag_valid <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
            frag_w0    <= '0;
            frag_w1    <= '0;
            frag_w2    <= '0;
        end else if (step && covered) begin
            frag_valid <= 1'b1;
            frag_x     <= x;
            frag_y     <= y;
            frag_w0    <= ecur[0];
            frag_w1    <= ecur[1];
            frag_w2    <= ecur[2];
        end else if (frag_valid && frag_ready) begin
            frag_valid <= 1'b0;
        end
    end

endmodule
